// File: rtl/sincos_cordic.sv
// Iterative rotation-mode CORDIC: degree angle in, sin/cos out, all Q16.16 sign-magnitude.
// Angle is reduced mod 360 by repeated subtraction, folded into [0,90], rotated, then unfolded.
module sincos_cordic #(
  parameter int          ITER  = 16,
  parameter logic [31:0] K_INV = 32'h0000_9B75
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        valid,
  output logic [31:0] sin_out,
  output logic [31:0] cos_out
);

  typedef enum logic [2:0] {IDLE, REDUCE, FOLD, ROTATE, DONE} state_e;

  localparam logic [30:0] D90    = 31'h005A_0000;
  localparam logic [30:0] D180   = 31'h00B4_0000;
  localparam logic [30:0] D270   = 31'h010E_0000;
  localparam logic [30:0] D360   = 31'h0168_0000;
  localparam logic [31:0] ONE    = 32'h0001_0000;
  localparam logic [3:0]  I_LAST = 4'(ITER - 1);

  // atan(2^-i) in degrees, Q16.16, rounded
  function automatic logic [31:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 32'h002D_0000;
      4'd1:    atan_lut = 32'h001A_90A7;
      4'd2:    atan_lut = 32'h000E_0947;
      4'd3:    atan_lut = 32'h0007_2001;
      4'd4:    atan_lut = 32'h0003_938B;
      4'd5:    atan_lut = 32'h0001_CA38;
      4'd6:    atan_lut = 32'h0000_E52A;
      4'd7:    atan_lut = 32'h0000_7297;
      4'd8:    atan_lut = 32'h0000_394C;
      4'd9:    atan_lut = 32'h0000_1CA6;
      4'd10:   atan_lut = 32'h0000_0E53;
      4'd11:   atan_lut = 32'h0000_0729;
      4'd12:   atan_lut = 32'h0000_0395;
      4'd13:   atan_lut = 32'h0000_01CA;
      4'd14:   atan_lut = 32'h0000_00E5;
      default: atan_lut = 32'h0000_0073;
    endcase
  endfunction

  // Two's complement -> sign-magnitude with clamp; exact angles substitute a fixed magnitude.
  function automatic logic [31:0] to_sm(input logic signed [31:0] v, input logic neg,
                                        input logic frc, input logic [31:0] frc_mag);
    logic [31:0] mag;
    logic        sgn;
    mag = v[31] ? $unsigned(-v) : $unsigned(v);
    sgn = neg ^ v[31];
    if (mag > ONE) mag = ONE;
    if (frc) begin
      mag = frc_mag;
      sgn = neg;
    end
    to_sm = (mag == 32'h0) ? 32'h0 : {sgn, mag[30:0]};
  endfunction

  state_e             state_q, state_d;
  logic               s_q, s_d;
  logic [30:0]        m_q, m_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]         i_q, i_d;
  logic [1:0]         quad_q, quad_d;
  logic               sneg_q, sneg_d, cneg_q, cneg_d, exact_q, exact_d;
  logic               busy_q, busy_d, valid_q, valid_d;
  logic [31:0]        sin_q, sin_d, cos_q, cos_d;

  logic [30:0]        fold_a;
  logic [1:0]         fold_q;
  logic signed [31:0] xs, ys, at;

  always_comb begin
    fold_q = 2'd3;
    fold_a = D360 - m_q;
    if (m_q < D90) begin
      fold_q = 2'd0;
      fold_a = m_q;
    end else if (m_q < D180) begin
      fold_q = 2'd1;
      fold_a = D180 - m_q;
    end else if (m_q < D270) begin
      fold_q = 2'd2;
      fold_a = m_q - D180;
    end
  end

  assign xs = x_q >>> i_q;
  assign ys = y_q >>> i_q;
  assign at = $signed(atan_lut(i_q));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    m_d     = m_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    quad_d  = quad_q;
    sneg_d  = sneg_q;
    cneg_d  = cneg_q;
    exact_d = exact_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = angle[31];
          m_d     = angle[30:0];
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (m_q >= D360) m_d = m_q - D360;
        else             state_d = FOLD;
      end
      FOLD: begin
        quad_d  = fold_q;
        x_d     = $signed(K_INV);
        y_d     = 32'sd0;
        z_d     = $signed({1'b0, fold_a});
        i_d     = 4'd0;
        cneg_d  = (fold_q == 2'd1) || (fold_q == 2'd2);
        sneg_d  = fold_q[1] ^ s_q;  // odd function: input sign folds into sin only
        exact_d = (m_q == 31'd0) || (m_q == D90) || (m_q == D180) || (m_q == D270);
        state_d = ROTATE;
      end
      ROTATE: begin
        if (!z_q[31]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - at;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + at;
        end
        i_d = i_q + 4'd1;
        if (i_q == I_LAST) state_d = DONE;
      end
      DONE: begin
        // odd quadrants land on the sin axis, even ones on the cos axis
        sin_d   = to_sm(y_q, sneg_q, exact_q, quad_q[0] ? ONE : 32'h0);
        cos_d   = to_sm(x_q, cneg_q, exact_q, quad_q[0] ? 32'h0 : ONE);
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      m_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      quad_q  <= '0;
      sneg_q  <= 1'b0;
      cneg_q  <= 1'b0;
      exact_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      m_q     <= m_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      quad_q  <= quad_d;
      sneg_q  <= sneg_d;
      cneg_q  <= cneg_d;
      exact_q <= exact_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;

endmodule

// File: tb/tb_sincos_cordic.sv
// Bench for sincos_cordic: directed plan plus random angles against a real-arithmetic trig model.
module tb_sincos_cordic;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] angle = 32'h0;
  logic        busy, valid;
  logic [31:0] sin_out, cos_out;
  int          checks = 0;
  int          failures = 0;

  sincos_cordic dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle(angle),
    .busy(busy), .valid(valid), .sin_out(sin_out), .cos_out(cos_out)
  );

  always #5 clk = ~clk;

  function automatic int sm2int(input logic [31:0] v);
    return v[31] ? -int'(v[30:0]) : int'(v[30:0]);
  endfunction

  function automatic logic [31:0] int2sm(input int v);
    if (v < 0) return {1'b1, 31'(-v)};
    return {1'b0, 31'(v)};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input int exp);
    int d;
    checks++;
    d = sm2int(obs) - exp;
    assert (d <= 16 && d >= -16 && obs !== 32'h8000_0000) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (+-0x10)", tag, obs, int2sm(exp));
    end
  endtask

  // Reference: reduce mod 360 degrees, evaluate ideal sin/cos, round to Q16.16.
  task automatic model(input logic [31:0] ang, output int es, output int ec,
                       output bit ex, output int r);
    longint m, red;
    real    rad, sv, cv;
    m   = longint'(ang[30:0]);
    r   = int'(m / 64'd23592960);
    red = m % 64'd23592960;
    ex  = (red % 64'd5898240) == 0;
    rad = (real'(red) / 65536.0) * 3.14159265358979323846 / 180.0;
    sv  = $sin(rad);
    cv  = $cos(rad);
    if (ang[31]) sv = -sv;
    es  = int'(sv * 65536.0);
    ec  = int'(cv * 65536.0);
  endtask

  // poke_at > 0: pulse a 60-degree start that many cycles into the operation.
  task automatic run(input logic [31:0] ang, input string tag, input int poke_at);
    int es, ec, r, cyc;
    bit ex;
    model(ang, es, ec, ex, r);
    @(negedge clk);
    angle = ang;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    angle = $urandom;
    chk_eq({tag, "_busy_acc"}, 32'(busy), 32'd1);
    chk_eq({tag, "_valid_drop"}, 32'(valid), 32'd0);
    cyc = 0;
    while (!valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (poke_at > 0 && cyc == poke_at) begin
        start = 1'b1;
        angle = 32'h003C_0000;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk_eq({tag, "_latency"}, 32'(cyc), 32'(19 + r));
    chk_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (ex) begin
      chk_eq({tag, "_sin"}, sin_out, int2sm(es));
      chk_eq({tag, "_cos"}, cos_out, int2sm(ec));
    end else begin
      chk_tol({tag, "_sin"}, sin_out, es);
      chk_tol({tag, "_cos"}, cos_out, ec);
    end
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_valid", 32'(valid), 32'd0);
    chk_eq("rst_sin", sin_out, 32'h0);
    chk_eq("rst_cos", cos_out, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    run(32'h001E_0000, "deg30", 0);

    // abort mid-rotation
    @(negedge clk);
    angle = 32'h001E_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    chk_eq("midrst_valid", 32'(valid), 32'd0);
    chk_eq("midrst_sin", sin_out, 32'h0);
    chk_eq("midrst_cos", cos_out, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run(32'h001E_0000, "deg30_after_rst", 0);

    run(32'h005A_0000, "deg90", 0);
    run(32'h00B4_0000, "deg180", 0);
    run(32'h80D2_0000, "degm210", 0);
    run(32'h02EE_0000, "deg750", 0);
    run(32'h001E_0000, "deg30_poked", 5);
    chk_eq("poked_valid_hold", 32'(valid), 32'd1);
    run(32'h003C_0000, "deg60", 0);
    run(32'h0168_0000, "deg360", 0);
    run(32'h805A_0000, "degm90", 0);
    run(32'h010E_0000, "deg270", 0);
    run(32'h0059_FFFF, "deg90_minus", 0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 4) == 0) a = 32'(32'h005A_0000 * $urandom_range(0, 15));
      else                           a = $urandom_range(0, 32'h05A0_0000);
      a[31] = 1'($urandom_range(0, 1));
      run(a, $sformatf("rand%0d_%h", k, a), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
